// File: rtl/rom_bus_arbiter.sv
// Round-robin arbiter sharing the single-port instruction ROM.
// Sequences one strobed ROM read per grant, with withdraw abort and timeout.
module rom_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  output logic [NUM_MASTERS-1:0]        m_grnt_n,
  output logic [NUM_MASTERS-1:0]        m_rdy_n,
  output logic [DATA_W-1:0]             m_rd_data,
  output logic                          bus_err,
  output logic                          rom_cs_n,
  output logic                          rom_as_n,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_rd_data,
  input  logic                          rom_rdy_n
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] win;
  logic [PW-1:0] nxt;
  logic [CW-1:0] cnt;
  logic          found;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && !m_req_n[(int'(ptr) + k) % NUM_MASTERS]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % NUM_MASTERS);
      end
    end
  end

  assign nxt = (sel == PW'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      cnt       <= '0;
      m_grnt_n  <= '1;
      m_rdy_n   <= '1;
      m_rd_data <= '0;
      bus_err   <= 1'b0;
      rom_cs_n  <= 1'b1;
      rom_as_n  <= 1'b1;
      rom_addr  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            sel      <= win;
            m_grnt_n <= ~(NUM_MASTERS'(1) << win);
            rom_cs_n <= 1'b0;
            rom_as_n <= 1'b0;
            rom_addr <= m_addr[win*ADDR_W +: ADDR_W];
            cnt      <= '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          rom_as_n <= 1'b1;
          // Ready beats a same-cycle withdraw; withdraw beats timeout.
          if (!rom_rdy_n) begin
            m_rd_data    <= rom_rd_data;
            m_rdy_n[sel] <= 1'b0;
            rom_cs_n     <= 1'b1;
            m_grnt_n     <= '1;
            state        <= DONE;
          end else if (m_req_n[sel]) begin
            rom_cs_n <= 1'b1;
            m_grnt_n <= '1;
            ptr      <= nxt;
            state    <= IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            m_rd_data    <= '0;
            m_rdy_n[sel] <= 1'b0;
            bus_err      <= 1'b1;
            rom_cs_n     <= 1'b1;
            m_grnt_n     <= '1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          m_rdy_n <= '1;
          bus_err <= 1'b0;
          ptr     <= nxt;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
